// File: rtl/keypad_matrix_scanner.sv
// Column-strobed keypad scanner: 2-flop row synchroniser, one shared press/release debounce counter,
// registered key code with one-cycle strobes. Define KEYPAD_AUTOREPEAT_EN to auto-repeat the held key.
module keypad_matrix_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 4000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    localparam int CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] keypad_row,
    output logic [NUM_COLS-1:0] keypad_column,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                key_released
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    if (NUM_ROWS < 2 || NUM_ROWS > 8 || NUM_COLS < 2 || NUM_COLS > 8 ||
        SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_matrix_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_ROWS-1:0] r_row_s1, r_row_s2;
    logic [COL_W-1:0]    r_col, w_col_nxt, w_col_adv;
    logic [DW_W-1:0]     r_dwell, w_dwell_nxt;
    logic [DB_W-1:0]     r_db, w_db_nxt;
    logic [ROW_W-1:0]    r_row, w_row_nxt, w_low_row;
    logic                w_any_low, w_row_hi, w_accept, w_release, w_repeat;
    logic [CODE_W-1:0]   r_key_code;
    logic                r_key_valid, r_key_held, r_key_released;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= keypad_row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        w_low_row = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!r_row_s2[i]) w_low_row = ROW_W'(i);
        end
    end

    assign w_any_low = ~&r_row_s2;
    assign w_row_hi  = r_row_s2[r_row];
    assign w_col_adv = (r_col == COL_W'(NUM_COLS - 1)) ? '0 : r_col + COL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_dwell_nxt = r_dwell;
        w_db_nxt    = r_db;
        w_row_nxt   = r_row;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_dwell == DW_W'(SCAN_DIV - 1)) begin
                    w_dwell_nxt = '0;
                    if (w_any_low) begin
                        w_row_nxt   = w_low_row;
                        w_db_nxt    = '0;
                        w_state_nxt = PRESS_DB;
                    end else begin
                        w_col_nxt = w_col_adv;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end
            end
            PRESS_DB: begin
                if (w_row_hi) begin
                    w_state_nxt = SCAN;
                    w_col_nxt   = w_col_adv;
                    w_dwell_nxt = '0;
                end else if (r_db == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_db_nxt = r_db + DB_W'(1);
                end
            end
            HELD: begin
                if (w_row_hi) begin
                    w_db_nxt    = '0;
                    w_state_nxt = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (!w_row_hi) begin
                    w_state_nxt = HELD;
                end else if (r_db == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_release   = 1'b1;
                    w_state_nxt = SCAN;
                    w_col_nxt   = w_col_adv;
                    w_dwell_nxt = '0;
                end else begin
                    w_db_nxt = r_db + DB_W'(1);
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE; count freezes outside HELD.
    assign w_repeat = (r_state == HELD) &&
                      (r_rep_first ? (r_rep_cnt == REP_W'(REPEAT_DELAY - 1))
                                   : (r_rep_cnt == REP_W'(REPEAT_RATE - 1)));

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state == HELD) begin
            if (w_repeat) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col          <= '0;
            r_dwell        <= '0;
            r_db           <= '0;
            r_row          <= '0;
            r_key_code     <= '0;
            r_key_valid    <= 1'b0;
            r_key_held     <= 1'b0;
            r_key_released <= 1'b0;
        end else begin
            r_col          <= w_col_nxt;
            r_dwell        <= w_dwell_nxt;
            r_db           <= w_db_nxt;
            r_row          <= w_row_nxt;
            r_key_valid    <= w_accept | w_repeat;
            r_key_released <= w_release;
            if (w_accept) begin
                r_key_code <= CODE_W'(r_row) * CODE_W'(NUM_COLS) + CODE_W'(r_col);
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign keypad_column = ~(NUM_COLS'(1) << r_col);
    assign key_code      = r_key_code;
    assign key_valid     = r_key_valid;
    assign key_held      = r_key_held;
    assign key_released  = r_key_released;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a physical keypad model (pressed[row][col] closes a row only while
// its column is driven) with directed and random key sequences checked against spec-level expectations.
module tb_keypad_matrix_scanner;
    localparam int NR      = 4;
    localparam int NC      = 4;
    localparam int SD      = 4;
    localparam int DB      = 8;
    localparam int RD      = 40;
    localparam int RR      = 10;
    localparam int LAT_MAX = 2 + NC * SD + DB + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [NR-1:0] keypad_row;
    logic [NC-1:0] keypad_column;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;
    logic          key_released;

    logic [NR-1:0][NC-1:0] pressed;
    logic [NR-1:0]         force_low;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int rel_cnt   = 0;
    int valid_cyc_q[$];

    keypad_matrix_scanner #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .keypad_row(keypad_row), .keypad_column(keypad_column),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .key_released(key_released)
    );

    // Clock and keypad contact model.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            keypad_row[r] = ~(|(pressed[r] & ~keypad_column)) & ~force_low[r];
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_valid) begin
            valid_cnt++;
            valid_cyc_q.push_back(cyc);
        end
        if (key_released) rel_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] col_pat(input int c);
        logic [NC-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return ~v;
    endfunction

    task automatic wait_valid(input int v0, output int lat);
        lat = 0;
        while (valid_cnt == v0 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_release(input int r0);
        int n = 0;
        while (rel_cnt == r0 && n < 60) begin
            tick();
            n++;
        end
    endtask

    // One complete press / hold / release of key (r,c).
    task automatic do_key(input int r, input int c, input int hold_cycles);
        int v0, r0, lat;
        v0 = valid_cnt;
        r0 = rel_cnt;
        pressed[r][c] = 1'b1;
        wait_valid(v0, lat);
        check("press_latency_in_bound", 32'(lat <= LAT_MAX), 1);
        check("key_code", 32'(key_code), 32'(r * NC + c));
        check("held_on_accept", 32'(key_held), 1);
        check("col_frozen", 32'(keypad_column), 32'(col_pat(c)));
        repeat (hold_cycles) tick();
        check("col_frozen_hold", 32'(keypad_column), 32'(col_pat(c)));
        check("single_valid", 32'(valid_cnt - v0), 1);
        check("no_early_release", 32'(rel_cnt - r0), 0);
        pressed[r][c] = 1'b0;
        wait_release(r0);
        check("release_strobe", 32'(rel_cnt - r0), 1);
        check("held_after_release", 32'(key_held), 0);
        check("scan_resumes_next_col", 32'(keypad_column), 32'(col_pat((c + 1) % NC)));
        check("code_persists", 32'(key_code), 32'(r * NC + c));
        tick();
        check("release_one_cycle", 32'(key_released), 0);
    endtask

    initial begin
        int v0, r0, lat, stay, n, base, rk, ck;
        int exp_off[$];
        int obs_off[$];

        reset     = 1'b1;
        pressed   = '0;
        force_low = '0;
        repeat (3) tick();
        check("rst_column", 32'(keypad_column), 32'(4'b1110));
        check("rst_code", 32'(key_code), 0);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_released", 32'(key_released), 0);
        reset = 1'b0;

        // Idle scan: each column driven SD cycles in turn.
        for (int t = 0; t < 20; t++) begin
            check("scan_column", 32'(keypad_column), 32'(col_pat((t / SD) % NC)));
            tick();
        end
        check("idle_no_valid", 32'(valid_cnt), 0);
        check("idle_no_release", 32'(rel_cnt), 0);

        // Key at row 2, column 1.
        do_key(2, 1, 30);

        // Row 0 glitch while column 3 is driven.
        n = 0;
        while (keypad_column == 4'b0111 && n < 40) begin tick(); n++; end
        n = 0;
        while (keypad_column != 4'b0111 && n < 40) begin tick(); n++; end
        check("glitch_found_col3", 32'(keypad_column), 32'(4'b0111));
        v0        = valid_cnt;
        stay      = 1;
        n         = 0;
        force_low = 4'b0001;
        while (n < 40) begin
            tick();
            n++;
            if (n == 5) force_low = '0;
            if (keypad_column != 4'b0111) break;
            stay++;
        end
        force_low = '0;
        check("glitch_col_frozen_in_debounce", 32'(stay > SD && stay < SD + DB), 1);
        check("glitch_resume_col0", 32'(keypad_column), 32'(4'b1110));
        check("glitch_no_valid", 32'(valid_cnt - v0), 0);
        check("glitch_not_held", 32'(key_held), 0);

        // Rows 1 and 3 on column 0, then a short bounce of row 1 while held.
        v0 = valid_cnt;
        r0 = rel_cnt;
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        wait_valid(v0, lat);
        check("multi_row_code", 32'(key_code), 4);
        pressed[1][0] = 1'b0;
        repeat (3) tick();
        pressed[1][0] = 1'b1;
        repeat (15) tick();
        check("bounce_no_release", 32'(rel_cnt - r0), 0);
        check("bounce_no_second_valid", 32'(valid_cnt - v0), 1);
        check("bounce_still_held", 32'(key_held), 1);
        pressed = '0;
        wait_release(r0);
        check("bounce_final_release", 32'(rel_cnt - r0), 1);

        // Random keys, random idle gaps and hold lengths.
        for (int i = 0; i < 6; i++) begin
            rk = $urandom_range(0, NR - 1);
            ck = $urandom_range(0, NC - 1);
            repeat ($urandom_range(0, 20)) tick();
            do_key(rk, ck, $urandom_range(2, 30));
        end

        // Reset while a key is held.
        v0 = valid_cnt;
        rk = $urandom_range(1, NR - 1);
        ck = $urandom_range(1, NC - 1);
        pressed[rk][ck] = 1'b1;
        wait_valid(v0, lat);
        check("pre_reset_held", 32'(key_held), 1);
        reset = 1'b1;
        tick();
        check("midrst_held", 32'(key_held), 0);
        check("midrst_column", 32'(keypad_column), 32'(4'b1110));
        check("midrst_code", 32'(key_code), 0);
        check("midrst_valid", 32'(key_valid), 0);
        check("midrst_released", 32'(key_released), 0);
        pressed = '0;
        reset   = 1'b0;
        tick();

        // Hold key 5 for 80 cycles after acceptance; repeats only when the feature is built in.
        for (int k = 0; k < 80; k++) begin
            if (k == 0 || (AUTOREP && k >= RD && (k - RD) % RR == 0)) exp_off.push_back(k);
        end
        v0 = valid_cnt;
        r0 = rel_cnt;
        pressed[1][1] = 1'b1;
        wait_valid(v0, lat);
        check("hold5_code", 32'(key_code), 5);
        repeat (79) tick();
        base = (valid_cyc_q.size() > v0) ? valid_cyc_q[v0] : 0;
        for (int i = v0; i < valid_cyc_q.size(); i++) begin
            if (valid_cyc_q[i] - base < 80) obs_off.push_back(valid_cyc_q[i] - base);
        end
        check("hold5_pulse_count", 32'(obs_off.size()), 32'(exp_off.size()));
        for (int i = 0; i < exp_off.size() && i < obs_off.size(); i++) begin
            check("hold5_pulse_offset", 32'(obs_off[i]), 32'(exp_off[i]));
        end
        pressed = '0;
        wait_release(r0);
        check("hold5_release", 32'(rel_cnt - r0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised single-clock successor to the 4x4 keypad scanner. It drives one active-low column at a time and samples the active-low rows through a 2-flop synchroniser. It debounces press and release with one shared counter, then reports a key code with a one-cycle valid strobe. A tick prescaler replaces derived clocks, so everything runs on clk and feeds the display/entry logic directly.

Parameters:
NUM_ROWS, 4, row inputs; legal range 2..8.
NUM_COLS, 4, column outputs; legal range 2..8.
SCAN_DIV, 100000, clk cycles each column is driven before rows are sampled; must be >= 4.
DEBOUNCE_CYCLES, 4000000, consecutive stable synced samples needed to accept a press or release; must be >= 2.
REPEAT_DELAY, 50000000, clk cycles held before the first auto-repeat (optional feature only).
REPEAT_RATE, 10000000, clk cycles between later auto-repeats (optional feature only).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
keypad_row  input  NUM_ROWS  raw row lines, active-low, asynchronous
keypad_column  output  NUM_COLS  column drive, one-cold (exactly one bit low)
key_code  output  CODE_W  row*NUM_COLS+col of the accepted key; CODE_W = $clog2(NUM_ROWS*NUM_COLS)
key_valid  output  1  one-cycle strobe: key_code is new
key_held  output  1  high while the accepted key is held, including release debounce
key_released  output  1  one-cycle strobe on debounced release

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - col index 0, so keypad_column = all ones except bit 0 low.
  - key_code 0, key_valid 0, key_held 0, key_released 0.
  - Synchroniser flops all ones; counters 0; state SCAN.
- Synchroniser: keypad_row passes through 2 flops (row_s). All decisions use row_s only.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1 with the current column driven.
  - At terminal count, if any row_s bit is 0, latch row = lowest-index low bit and col = current column, clear the debounce counter, go PRESS_DB. keypad_column stays frozen.
  - Otherwise advance col, wrapping NUM_COLS-1 -> 0, and reset the dwell counter.
- PRESS_DB:
  - Each cycle row_s[row]==0 increments the debounce counter.
  - Any cycle row_s[row]==1 aborts: go SCAN, advance col, no strobe.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low: key_code <= row*NUM_COLS+col, key_valid=1 for exactly one cycle (the cycle after the transition), key_held=1, go HELD.
- HELD:
  - Column stays frozen. Keys on other rows or columns are ignored (no rollover).
  - row_s[row]==1 -> clear the counter, go RELEASE_DB.
- RELEASE_DB:
  - row_s[row]==0 returns to HELD with no strobe.
  - DEBOUNCE_CYCLES consecutive highs -> key_released=1 for one cycle, key_held=0, go SCAN, advance col.
- key_code persists after release and changes only on a new key_valid.
- Simultaneous presses on the same column: lowest row index wins. Presses on different columns: the first column scanned wins.
- Reset mid-operation (any state) returns to reset values on the next edge. Strobes are suppressed that cycle.
- Worst-case latency from a stable press edge to key_valid is 2 + NUM_COLS*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, a repeat counter runs.
  - At REPEAT_DELAY cycles, and every REPEAT_RATE cycles after that, key_valid pulses for one cycle with the same key_code.
  - The counter clears on entering HELD and holds its value during RELEASE_DB. A bounce back to HELD resumes the count without a restart.
- Undefined: exactly one key_valid per debounced press. REPEAT_* parameters exist but are unused and no repeat logic is synthesised.

Test Plan:
All scenarios use NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=10.
1. Reset for 3 cycles, rows all 1 -> keypad_column cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; no strobes.
2. Hold row 2 low only while column 1 is driven, for 100 cycles -> key_valid pulses once, key_code=9, key_held=1. Column stays at 1101 until release. After release, key_released pulses once and scanning resumes at column 2.
3. Glitch row 0 low for 5 cycles during column 3 -> PRESS_DB aborts; no key_valid; scan continues at column 0.
4. Rows 1 and 3 both low on column 0 -> key_code=4. Then release and re-press bounce of 3 cycles during HELD -> no key_released, no second key_valid.
5. Assert reset during HELD -> next cycle key_held=0, keypad_column=1110, key_code=0.
6. With KEYPAD_AUTOREPEAT_EN defined, hold key 5 for 80 cycles after acceptance -> key_valid at +0, +40, +50, +60, +70. With it undefined -> a single pulse.
